// File: rtl/imm_instr_packer.sv
// Packs register fields and a 12-bit immediate into I/S-type RV32 words
// and streams them to instruction memory. Optional: IMM_RANGE_CHECK_EN.
module imm_instr_packer #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_imm_src,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W+1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              done,
  output logic              imm_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W+1:0] BASE = BASE_ADDR[ADDR_W+1:0];
  localparam logic [ADDR_W+1:0] STEP = (ADDR_W+2)'(4);
  localparam logic [ADDR_W:0]   ONE  = (ADDR_W+1)'(1);

  logic [1:0]    state;
  logic [ADDR_W:0] nw;
  logic [ADDR_W:0] issued;
  logic [ADDR_W:0] written;
  logic [ADDR_W:0] written_nxt;
  logic [31:0]   packed_word;
  logic          accept;
  logic          xfer;
  logic          imm_bad;

  assign in_ready = (state == S_RUN) && (issued < nw)
                 && (!wr_en || wr_ready);
  assign accept = in_valid && in_ready;
  assign xfer   = wr_en && wr_ready;
  assign written_nxt = xfer ? written + ONE : written;

`ifdef IMM_RANGE_CHECK_EN
  assign imm_bad = ($signed(in_imm) < -32'sd2048)
                || ($signed(in_imm) > 32'sd2047);
`else
  logic unused_imm;
  assign unused_imm = ^in_imm[31:12];
  assign imm_bad = 1'b0;
`endif

  // Select the field layout for the requested immediate format
  always_comb begin
    packed_word = '0;
    unique case (1'b1)
      in_imm_src:
        packed_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:0], in_opcode};
      default:
        packed_word = {in_imm[11:0], in_rs1, in_funct3,
                       in_rd, in_opcode};
    endcase
  end

  // Run-length FSM, counters, address and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      nw      <= '0;
      issued  <= '0;
      written <= '0;
      wr_en   <= 1'b0;
      wr_data <= '0;
      wr_addr <= BASE;
      done    <= 1'b0;
      imm_err <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_RUN;
            nw      <= num_words;
            issued  <= '0;
            written <= '0;
            wr_addr <= BASE;
            done    <= 1'b0;
            imm_err <= 1'b0;
          end
        end
        S_RUN: begin
          if (accept) begin
            issued  <= issued + ONE;
            wr_data <= packed_word;
            if (imm_bad)
              imm_err <= 1'b1;
          end
          if (accept)
            wr_en <= 1'b1;
          else if (xfer)
            wr_en <= 1'b0;
          if (xfer)
            wr_addr <= wr_addr + STEP;
          written <= written_nxt;
          if (written_nxt == nw) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
